// File: rtl/pipeline_lut_multiplier_param.sv
// Three-stage quarter-square LUT multiplier with per-stage valid/ready flow control.
// Defining PIPELINE_LUT_MULTIPLIER_MAC_EN adds an output-side accumulator (acc_clr / acc_sum).
module pipeline_lut_multiplier_param #(
   parameter int WIDTH  = 8,
   parameter bit SIGNED = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
`ifdef PIPELINE_LUT_MULTIPLIER_MAC_EN
   input  logic                 acc_clr,
   output logic [2*WIDTH+7:0]   acc_sum,
`endif
   output logic [2*WIDTH-1:0]   product
);

   localparam int IW    = WIDTH + 1;
   localparam int PW    = 2 * WIDTH;
   localparam int DEPTH = 1 << IW;

   // Constant square/4 table, resolved at elaboration.
   logic [PW-1:0] rom [DEPTH];
   for (genvar g = 0; g < DEPTH; g++) begin : g_rom
      assign rom[g] = PW'((g * g) / 4);
   end

   logic          v1, v2, v3;
   logic          load1, load2, load3;
   logic [IW-1:0] ax, bx, s, d, s_abs, d_abs;
   logic [IW-1:0] i1, i2;
   logic [PW-1:0] q1, q2;

   assign load3     = !v3 || out_ready;
   assign load2     = !v2 || load3;
   assign load1     = !v1 || load2;
   assign in_ready  = load1;
   assign out_valid = v3;

   // |a+b| and |a-b| never exceed 2^WIDTH in signed mode or 2^(WIDTH+1)-2 unsigned,
   // so WIDTH+1 bits hold both; bit WIDTH of d is its sign in either mode.
   always_comb begin
      ax    = {SIGNED & a[WIDTH-1], a};
      bx    = {SIGNED & b[WIDTH-1], b};
      s     = ax + bx;
      d     = ax - bx;
      s_abs = (SIGNED && s[WIDTH]) ? -s : s;
      d_abs = d[WIDTH] ? -d : d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         v3      <= 1'b0;
         i1      <= '0;
         i2      <= '0;
         q1      <= '0;
         q2      <= '0;
         product <= '0;
      end else begin
         if (load1) begin
            v1 <= in_valid;
            if (in_valid) begin
               i1 <= s_abs;
               i2 <= d_abs;
            end
         end
         if (load2) begin
            v2 <= v1;
            if (v1) begin
               q1 <= rom[i1];
               q2 <= rom[i2];
            end
         end
         if (load3) begin
            v3 <= v2;
            if (v2) product <= q1 - q2;
         end
      end
   end

`ifdef PIPELINE_LUT_MULTIPLIER_MAC_EN
   logic          out_fire;
   logic [PW+7:0] prod_ext;

   assign out_fire = v3 && out_ready;
   assign prod_ext = {{8{SIGNED & product[PW-1]}}, product};

   always_ff @(posedge clk) begin
      if (!rst_n)        acc_sum <= '0;
      else if (out_fire) acc_sum <= (acc_clr ? '0 : acc_sum) + prod_ext;
      else if (acc_clr)  acc_sum <= '0;
   end
`endif

endmodule
